// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: context-manager request, branch-hazard and instruction-memory signals of fetch_sequencer
interface fetch_sequencer_if #(
   parameter int LEN_WORD = 32,
   parameter int LEN_CONTEXT = 8
);
   logic                   fetch_order;
   logic [LEN_WORD-1:0]    fetch_pc;
   logic [LEN_CONTEXT-1:0] fetch_context;
   logic                   fetch_done;
   logic [LEN_WORD-1:0]    fetch_instr;
   logic                   branch_hazard;
   logic [LEN_CONTEXT-1:0] hazard_context_info;
   logic                   mem_req;
   logic [LEN_WORD-1:0]    mem_addr;
   logic                   mem_gnt;
   logic                   mem_rvalid;
   logic [LEN_WORD-1:0]    mem_rdata;
   logic                   busy;
   modport slave (
      input  fetch_order, fetch_pc, fetch_context, branch_hazard, hazard_context_info,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output fetch_done, fetch_instr, mem_req, mem_addr, busy
   );
   modport master (
      output fetch_order, fetch_pc, fetch_context, branch_hazard, hazard_context_info,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  fetch_done, fetch_instr, mem_req, mem_addr, busy
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch with branch-hazard squash; FETCH_LINE_BUF_EN adds a one-entry line buffer
module fetch_sequencer #(
   parameter int LEN_WORD = 32,
   parameter int LEN_CONTEXT = 8
) (
   input logic              clk,
   input logic              rst,
   fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, SQUASH} state_t;
   state_t                 state, state_nxt;
   logic [LEN_WORD-1:0]    req_pc;
   logic [LEN_CONTEXT-1:0] req_cntx;
   logic                   kill, kill_cap, capture, deliver, take_hit, hit;
   logic [LEN_WORD-1:0]    hit_instr;
   assign kill     = bus.branch_hazard && |(bus.hazard_context_info & req_cntx);
   assign kill_cap = bus.branch_hazard && |(bus.hazard_context_info & bus.fetch_context);
   assign bus.busy = state != IDLE;
`ifdef FETCH_LINE_BUF_EN
   logic                buf_valid;
   logic [LEN_WORD-1:0] buf_pc, buf_instr;
   // line buffer remembers the last instruction actually delivered from memory
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         buf_valid <= 1'b0;
         buf_pc    <= '0;
         buf_instr <= '0;
      end else if (deliver) begin
         buf_valid <= 1'b1;
         buf_pc    <= req_pc;
         buf_instr <= bus.mem_rdata;
      end
   assign hit       = buf_valid && bus.fetch_pc == buf_pc;
   assign hit_instr = buf_instr;
`else
   assign hit       = 1'b0;
   assign hit_instr = '0;
`endif
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   // next state and one-cycle control strobes
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      deliver   = 1'b0;
      take_hit  = 1'b0;
      unique case (state)
         IDLE:
            if (bus.fetch_order && !kill_cap) begin
               take_hit  = hit;
               capture   = !hit;
               state_nxt = hit ? IDLE : REQ;
            end
         REQ:
            if (kill) state_nxt = bus.mem_gnt ? SQUASH : IDLE;
            else if (bus.mem_gnt) state_nxt = WAIT;
         WAIT:
            if (bus.mem_rvalid) begin
               deliver   = !kill;
               state_nxt = IDLE;
            end else if (kill) state_nxt = SQUASH;
         SQUASH:
            if (bus.mem_rvalid) state_nxt = IDLE;
      endcase
   end
   // registered request, address and instruction return
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         req_pc          <= '0;
         req_cntx        <= '0;
         bus.mem_req     <= 1'b0;
         bus.mem_addr    <= '0;
         bus.fetch_done  <= 1'b0;
         bus.fetch_instr <= '0;
      end else begin
         bus.mem_req    <= state_nxt == REQ;
         bus.fetch_done <= deliver || take_hit;
         if (capture) begin
            req_pc       <= bus.fetch_pc;
            req_cntx     <= bus.fetch_context;
            bus.mem_addr <= bus.fetch_pc;
         end
         if (deliver) bus.fetch_instr <= bus.mem_rdata;
         else if (take_hit) bus.fetch_instr <= hit_instr;
      end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table vectors, hand sequences and randomized transactions against a timeline model
module tb_fetch_sequencer;
   localparam int LW = 32;
   localparam int LC = 8;
`ifdef FETCH_LINE_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif
   typedef struct {
      logic [LW-1:0] pc;
      logic [LC-1:0] cntx;
      int            g;
      int            r;
      bit            haz;
      logic [LC-1:0] hmask;
      int            h;
      logic [LW-1:0] rdata;
   } txn_t;
   typedef struct {
      int            dones;
      int            done_cyc;
      int            mreq;
      int            busy;
      int            addr_err;
      logic [LW-1:0] instr;
   } res_t;
   typedef struct {
      txn_t t;
      res_t e;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int errors = 0;
   bit            m_bv;
   logic [LW-1:0] m_bpc, m_binstr;
   always #5 clk = ~clk;
   fetch_sequencer_if #(.LEN_WORD(LW), .LEN_CONTEXT(LC)) bus ();
   fetch_sequencer #(.LEN_WORD(LW), .LEN_CONTEXT(LC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   task automatic chk(input string nm, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask
   task automatic idle_inputs();
      bus.fetch_order = 1'b0;
      bus.fetch_pc = '0;
      bus.fetch_context = '0;
      bus.branch_hazard = 1'b0;
      bus.hazard_context_info = '0;
      bus.mem_gnt = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata = '0;
   endtask
   // one order at cycle 0, grant at g+1, rvalid r cycles later, optional hazard at cycle h, one trailing idle cycle
   task automatic run_txn(input txn_t t, output res_t o);
      o = '{default: 0};
      for (int c = 0; c <= t.g + t.r + 3; c++) begin
         if (bus.fetch_done === 1'b1) begin
            o.dones++;
            o.done_cyc = c;
            o.instr = bus.fetch_instr;
         end
         if (bus.mem_req !== 1'b0) begin
            o.mreq++;
            if (bus.mem_addr !== t.pc) o.addr_err++;
         end
         if (bus.busy !== 1'b0) o.busy++;
         bus.fetch_order = c == 0;
         bus.fetch_pc = t.pc;
         bus.fetch_context = t.cntx;
         bus.branch_hazard = t.haz && c == t.h;
         bus.hazard_context_info = t.hmask;
         bus.mem_gnt = c == t.g + 1;
         bus.mem_rvalid = c == t.g + t.r + 1;
         bus.mem_rdata = (c == t.g + t.r + 1) ? t.rdata : LW'($urandom);
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask
   task automatic cmp(input string nm, input res_t o, input res_t e);
      chk({nm, ".dones"}, o.dones, e.dones);
      chk({nm, ".done_cyc"}, o.done_cyc, e.done_cyc);
      chk({nm, ".mreq_cycles"}, o.mreq, e.mreq);
      chk({nm, ".busy_cycles"}, o.busy, e.busy);
      chk({nm, ".addr_err"}, o.addr_err, e.addr_err);
      chk({nm, ".instr"}, o.instr, e.instr);
   endtask
   // expected outcome from the timeline: grant cycle, return cycle and the first matching kill cycle
   function automatic res_t model(input txn_t t);
      res_t e;
      int gc, vc, k;
      e = '{default: 0};
      gc = t.g + 1;
      vc = t.g + t.r + 1;
      k = (t.haz && (t.hmask & t.cntx) != 0) ? t.h : 1000;
      if (k == 0) return e;
      if (BUF_EN && m_bv && t.pc == m_bpc) begin
         e.dones = 1;
         e.done_cyc = 1;
         e.instr = m_binstr;
         return e;
      end
      if (k < gc) begin
         e.mreq = k;
         e.busy = k;
         return e;
      end
      e.mreq = gc;
      e.busy = vc;
      if (k > vc) begin
         e.dones = 1;
         e.done_cyc = vc + 1;
         e.instr = t.rdata;
         m_bv = 1'b1;
         m_bpc = t.pc;
         m_binstr = t.rdata;
      end
      return e;
   endfunction
   initial begin
      vec_t vecs[9];
      res_t o, e;
      txn_t t;
      int d;
      vecs[0] = '{'{32'h100, 8'h01, 0, 1, 1'b0, 8'h00, 0, 32'hDEADBEEF}, '{1, 3, 1, 2, 0, 32'hDEADBEEF}};
      vecs[1] = '{'{32'h040, 8'h04, 2, 1, 1'b1, 8'h0C, 1, 32'h11111111}, '{0, 0, 1, 1, 0, 32'h0}};
      vecs[2] = '{'{32'h044, 8'h04, 0, 2, 1'b1, 8'h04, 2, 32'h22222222}, '{0, 0, 1, 3, 0, 32'h0}};
      vecs[3] = '{'{32'h080, 8'h04, 0, 1, 1'b0, 8'h00, 0, 32'h12345678}, '{1, 3, 1, 2, 0, 32'h12345678}};
      vecs[4] = '{'{32'h060, 8'h02, 1, 2, 1'b1, 8'h02, 4, 32'h33333333}, '{0, 0, 2, 4, 0, 32'h0}};
      vecs[5] = '{'{32'h064, 8'h02, 1, 2, 1'b1, 8'h10, 4, 32'hCAFEF00D}, '{1, 5, 2, 4, 0, 32'hCAFEF00D}};
      vecs[6] = '{'{32'h070, 8'h08, 1, 3, 1'b1, 8'h08, 2, 32'h44444444}, '{0, 0, 2, 5, 0, 32'h0}};
      vecs[7] = '{'{32'h074, 8'h20, 0, 1, 1'b1, 8'h20, 0, 32'h55555555}, '{0, 0, 0, 0, 0, 32'h0}};
      vecs[8] = '{'{32'h078, 8'h01, 0, 1, 1'b1, 8'h01, 3, 32'h0BADCAFE}, '{1, 3, 1, 2, 0, 32'h0BADCAFE}};
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset.fetch_done", bus.fetch_done, 0);
      chk("reset.fetch_instr", bus.fetch_instr, 0);
      chk("reset.mem_req", bus.mem_req, 0);
      chk("reset.mem_addr", bus.mem_addr, 0);
      chk("reset.busy", bus.busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      foreach (vecs[i]) begin
         run_txn(vecs[i].t, o);
         cmp($sformatf("vec%0d", i), o, vecs[i].e);
      end
      // reset in the middle of WAIT, then a stray return
      bus.fetch_order = 1'b1;
      bus.fetch_pc = 32'h300;
      bus.fetch_context = 8'h01;
      @(posedge clk);
      #1;
      bus.fetch_order = 1'b0;
      bus.mem_gnt = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_gnt = 1'b0;
      chk("midwait.busy_before", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("midwait.busy", bus.busy, 0);
      chk("midwait.mem_req", bus.mem_req, 0);
      chk("midwait.mem_addr", bus.mem_addr, 0);
      chk("midwait.fetch_instr", bus.fetch_instr, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'h77777777;
      d = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         bus.mem_rvalid = 1'b0;
         d += int'(bus.fetch_done) + int'(bus.busy) + int'(bus.mem_req) + int'(bus.fetch_instr != 0);
      end
      chk("midwait.stray_rvalid_activity", d, 0);
      m_bv = 1'b0;
`ifdef FETCH_LINE_BUF_EN
      t = '{32'h200, 8'h02, 0, 1, 1'b0, 8'h00, 0, 32'hA5A5A5A5};
      run_txn(t, o);
      cmp("buf.first", o, '{1, 3, 1, 2, 0, 32'hA5A5A5A5});
      t.rdata = 32'h12121212;
      run_txn(t, o);
      cmp("buf.hit", o, '{1, 1, 0, 0, 0, 32'hA5A5A5A5});
      t = '{32'h200, 8'h02, 0, 1, 1'b1, 8'h06, 0, 32'h13131313};
      run_txn(t, o);
      cmp("buf.hit_killed", o, '{0, 0, 0, 0, 0, 32'h0});
`endif
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_bv = 1'b0;
      for (int n = 0; n < 300; n++) begin
         t.pc = 32'h1000 | (LW'($urandom_range(0, 7)) << 2);
         t.cntx = LC'(1) << $urandom_range(0, LC - 1);
         t.g = $urandom_range(0, 3);
         t.r = $urandom_range(1, 3);
         t.haz = $urandom_range(0, 1) == 1;
         t.hmask = ($urandom_range(0, 1) == 1) ? (t.cntx | LC'($urandom)) : (LC'($urandom) & ~t.cntx);
         t.h = $urandom_range(0, t.g + t.r + 2);
         t.rdata = $urandom;
         e = model(t);
         run_txn(t, o);
         cmp($sformatf("rnd%0d", n), o, e);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter LEN_WORD, default 32: width of PC, address and instruction.
REQ-002 SHALL have parameter LEN_CONTEXT, default 8: width of one-hot context masks.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1, the clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have ports fetch_order (in, 1), fetch_pc (in, LEN_WORD) and fetch_context (in, LEN_CONTEXT): a one-hot context fetch request from the context manager.
REQ-006 SHALL have ports fetch_done (out, 1) and fetch_instr (out, LEN_WORD): one-cycle pulse returning an instruction.
REQ-007 SHALL have ports branch_hazard (in, 1) and hazard_context_info (in, LEN_CONTEXT): mask of discarded contexts.
REQ-008 SHALL have ports mem_req (out, 1), mem_addr (out, LEN_WORD) and mem_gnt (in, 1): instruction-memory request handshake.
REQ-009 SHALL have ports mem_rvalid (in, 1) and mem_rdata (in, LEN_WORD): memory read return, latency of 1 or more cycles after grant.
REQ-010 SHALL have port busy (out, 1): high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT and SQUASH, with at most one outstanding memory access.
REQ-012 In IDLE with fetch_order=1 and no kill (REQ-017), SHALL capture fetch_pc and fetch_context into req_pc and req_cntx, and enter REQ on the next edge.
REQ-013 In REQ, SHALL drive mem_req=1 and mem_addr=req_pc, both registered.
REQ-014 On the edge where mem_req and mem_gnt are both 1, SHALL move REQ to WAIT.
REQ-015 When mem_rvalid=1 in WAIT, SHALL register mem_rdata to fetch_instr, pulse fetch_done for exactly one cycle and return to IDLE.
REQ-016 Minimum order-to-done latency SHALL be 3 cycles, given grant in the first REQ cycle and rvalid in the cycle after grant.
REQ-017 Kill condition: branch_hazard=1 and (hazard_context_info & req_cntx) != 0; for a capture in IDLE, fetch_context is used in place of req_cntx.
REQ-018 On kill in REQ before grant, SHALL drop mem_req and return to IDLE; if the kill and mem_gnt occur in the same cycle, SHALL enter SQUASH.
REQ-019 On kill in WAIT, SHALL enter SQUASH; if the kill and mem_rvalid occur in the same cycle, SHALL suppress fetch_done and go to IDLE.
REQ-020 In SQUASH, SHALL consume the next mem_rvalid without asserting fetch_done, then go to IDLE.
REQ-021 A fetch_order in IDLE that is killed in its capture cycle SHALL be ignored.
REQ-022 fetch_order SHALL be ignored in all states other than IDLE; the requester holds it until fetch_done.
REQ-023 A hazard whose mask does not intersect req_cntx SHALL have no effect on the access in progress.
REQ-024 mem_rvalid outside WAIT and SQUASH SHALL be ignored.

Reset
REQ-025 While rst=1, SHALL set state=IDLE, mem_req=0, mem_addr=0, fetch_done=0, fetch_instr=0, busy=0, req_pc=0 and req_cntx=0, asynchronously.
REQ-026 Reset in the middle of an access SHALL abandon it; a later stray mem_rvalid SHALL be ignored per REQ-024.

Configuration
REQ-027 With FETCH_LINE_BUF_EN defined, SHALL keep a one-entry buffer (valid, tag pc, instr) filled on every non-squashed return.
REQ-028 With the buffer enabled, an IDLE order whose fetch_pc equals the tag while valid=1 SHALL pulse fetch_done with the buffered instr on the next cycle, issue no mem_req and stay in IDLE.
REQ-029 With the buffer enabled, reset SHALL clear valid, and a buffer hit SHALL still honour the REQ-017 kill.
REQ-030 Without FETCH_LINE_BUF_EN, no buffer logic SHALL exist and every order SHALL go to memory.

Verification
REQ-031 Basic: order pc=0x100 with grant on the first REQ cycle and rvalid the cycle after, rdata=0xDEADBEEF -> done pulses once at cycle 3 with instr=0xDEADBEEF, then busy=0.
REQ-032 Pre-grant kill: order pc=0x40, cntx=0x04, gnt held 0, hazard info=0x0C -> mem_req drops next cycle, no done, state IDLE.
REQ-033 In-flight kill: after grant, hazard info=0x04 matching cntx=0x04, rvalid 2 cycles later -> no done; a new order pc=0x80 is then accepted normally.
REQ-034 Simultaneous: kill and rvalid in the same cycle -> fetch_done stays 0; non-matching hazard info=0x10 -> done is delivered.
REQ-035 Reset mid-WAIT: assert rst during WAIT, then inject a stray rvalid -> no done and all outputs 0.
REQ-036 FETCH_LINE_BUF_EN: fetch pc=0x200 twice -> the second order produces done after 1 cycle, mem_req stays 0 and instr matches the first fetch.
